// File: rtl/riscv_pkg.sv
// Shared types for the riscv_cpu five-stage core: opcode/funct constants,
// ALU operation enum, control bundle, inter-stage bus structs, memory sizes,
// and the decode/immediate/ALU helper functions used by the top.
package riscv_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BYTE    = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_byte;
    logic    branch;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // All-zero control word: the bubble that every unsupported encoding maps to.
  localparam ctrl_t CTRL_NONE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                  mem_byte: 1'b0, branch: 1'b0, alu_src: 1'b0,
                                  alu_op: ALU_ADD};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_byte;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } mem_wb_t;

  function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = CTRL_NONE;
    case (instr[6:0])
      OP_RTYPE: begin
        if (instr[31:25] == F7_BASE && instr[14:12] == F3_ADD_SUB) begin
          c.reg_write = 1'b1; c.alu_op = ALU_ADD;
        end else if (instr[31:25] == F7_SUB && instr[14:12] == F3_ADD_SUB) begin
          c.reg_write = 1'b1; c.alu_op = ALU_SUB;
        end else if (instr[31:25] == F7_BASE && instr[14:12] == F3_AND) begin
          c.reg_write = 1'b1; c.alu_op = ALU_AND;
        end else if (instr[31:25] == F7_BASE && instr[14:12] == F3_OR) begin
          c.reg_write = 1'b1; c.alu_op = ALU_OR;
        end else if (instr[31:25] == F7_BASE && instr[14:12] == F3_SLT) begin
          c.reg_write = 1'b1; c.alu_op = ALU_SLT;
        end
      end
      OP_IMM: begin
        if (instr[14:12] == F3_ADD_SUB) begin
          c.reg_write = 1'b1; c.alu_src = 1'b1;
        end
      end
      OP_LOAD: begin
        if (instr[14:12] == F3_BYTE || instr[14:12] == F3_WORD) begin
          c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1;
          c.mem_byte  = (instr[14:12] == F3_BYTE);
        end
      end
      OP_STORE: begin
        if (instr[14:12] == F3_BYTE || instr[14:12] == F3_WORD) begin
          c.mem_write = 1'b1; c.alu_src = 1'b1;
          c.mem_byte  = (instr[14:12] == F3_BYTE);
        end
      end
      OP_BRANCH: begin
        if (instr[14:12] == F3_BEQ) c.branch = 1'b1;
      end
      default: c = CTRL_NONE;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] instr);
    case (instr[6:0])
      OP_STORE:  return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH: return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default:   return {{20{instr[31]}}, instr[31:20]};
    endcase
  endfunction

  function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, (sa < sb)};
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32 x 32-bit register file: two combinational read ports with write-through
// from the WB port, x0 hard-wired to zero. Contents are not reset.
module riscv_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] Regs [0:31];

  // WB write port; writes to x0 are dropped
  always_ff @(posedge clk_i) begin
    if (we_i && waddr_i != 5'd0) Regs[waddr_i] <= wdata_i;
  end

  // Read ports; a same-cycle WB write to the read register is passed through
  always_comb begin
    rdata1_o = Regs[raddr1_i];
    rdata2_o = Regs[raddr2_i];
    if (we_i && waddr_i == raddr1_i) rdata1_o = wdata_i;
    if (we_i && waddr_i == raddr2_i) rdata2_o = wdata_i;
    if (raddr1_i == 5'd0) rdata1_o = 32'h0;
    if (raddr2_i == 5'd0) rdata2_o = 32'h0;
  end

endmodule

// File: rtl/riscv_cpu.sv
// riscv_cpu: five-stage in-order RV32I-subset core (IF, ID, EX, MEM, WB) with
// on-chip IMem/DMem and register file. RAW hazards are handled by an
// interlock (no forwarding); beq resolves in EX and flushes two slots.
// Optional per-edge trace under the DEBUG_TRACE_EN macro.
module riscv_cpu
  import riscv_pkg::*;
(
  input logic clock,
  input logic reset
);

  logic [31:0] pc_q, pc_d, instr;
  if_id_t      if_id_q, if_id_bus_in;
  id_ex_t      id_ex_q, id_ex_bus_in;
  ex_mem_t     ex_mem_q, ex_mem_bus_in;
  mem_wb_t     mem_wb_q, mem_wb_bus_in, mem_wb_bus_out;
  ctrl_t       ctrl_signals;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, br_target, dmem_rword;
  logic [4:0]  rs1, rs2;
  logic [7:0]  load_byte;
  logic        uses_rs1, uses_rs2, hz_ex, hz_mem, stall, br_taken;

  // ---------------- IF ----------------
  if (1'b1) begin : if_stage
    logic [31:0] PC;
    // Program counter; cleared to 0 so the first fetch after release is word 0
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) PC <= 32'h0;
      else        PC <= pc_d;
    end
    assign pc_q = PC;
  end

  if (1'b1) begin : imem
    logic [31:0] IMem [0:IMEM_DEPTH-1];
    assign instr = IMem[pc_q[9:2]];
  end

  // Next PC: a taken branch wins over a stall, otherwise sequential
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (br_taken)   pc_d = br_target;
    else if (stall) pc_d = pc_q;
  end

  // IF/ID next value: flush on taken branch, hold on stall
  always_comb begin
    if_id_bus_in = if_id_q;
    if (br_taken) begin
      if_id_bus_in = '0;
    end else if (!stall) begin
      if_id_bus_in.pc    = pc_q;
      if_id_bus_in.instr = instr;
    end
  end

  // ---------------- ID ----------------
  assign ctrl_signals = decode_ctrl(if_id_q.instr);
  assign rs1 = if_id_q.instr[19:15];
  assign rs2 = if_id_q.instr[24:20];
  assign uses_rs1 = ctrl_signals.reg_write | ctrl_signals.mem_write | ctrl_signals.branch;
  assign uses_rs2 = ctrl_signals.mem_write | ctrl_signals.branch |
                    (ctrl_signals.reg_write & ~ctrl_signals.alu_src);

  riscv_regfile regfile (
    .clk_i    (clock),
    .we_i     (mem_wb_q.reg_write),
    .waddr_i  (mem_wb_q.rd),
    .wdata_i  (mem_wb_q.wdata),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_val),
    .rdata2_o (rs2_val)
  );

  // RAW interlock against producers still in EX or MEM (WB is covered by write-through)
  always_comb begin
    hz_ex  = id_ex_q.ctrl.reg_write && (id_ex_q.rd != 5'd0) &&
             ((uses_rs1 && rs1 == id_ex_q.rd) || (uses_rs2 && rs2 == id_ex_q.rd));
    hz_mem = ex_mem_q.reg_write && (ex_mem_q.rd != 5'd0) &&
             ((uses_rs1 && rs1 == ex_mem_q.rd) || (uses_rs2 && rs2 == ex_mem_q.rd));
    stall  = hz_ex | hz_mem;
  end

  // ID/EX next value: bubble on stall or flush
  always_comb begin
    id_ex_bus_in = '0;
    if (!br_taken && !stall) begin
      id_ex_bus_in.ctrl    = ctrl_signals;
      id_ex_bus_in.pc      = if_id_q.pc;
      id_ex_bus_in.rs1_val = rs1_val;
      id_ex_bus_in.rs2_val = rs2_val;
      id_ex_bus_in.imm     = imm_gen(if_id_q.instr);
      id_ex_bus_in.rd      = if_id_q.instr[11:7];
    end
  end

  // ---------------- EX ----------------
  // ALU, beq compare and EX/MEM next value
  always_comb begin
    alu_b     = id_ex_q.ctrl.alu_src ? id_ex_q.imm : id_ex_q.rs2_val;
    alu_res   = alu_exec(id_ex_q.ctrl.alu_op, id_ex_q.rs1_val, alu_b);
    br_taken  = id_ex_q.ctrl.branch && (id_ex_q.rs1_val == id_ex_q.rs2_val);
    br_target = id_ex_q.pc + id_ex_q.imm;
    ex_mem_bus_in.reg_write  = id_ex_q.ctrl.reg_write;
    ex_mem_bus_in.mem_read   = id_ex_q.ctrl.mem_read;
    ex_mem_bus_in.mem_write  = id_ex_q.ctrl.mem_write;
    ex_mem_bus_in.mem_byte   = id_ex_q.ctrl.mem_byte;
    ex_mem_bus_in.alu_res    = alu_res;
    ex_mem_bus_in.store_data = id_ex_q.rs2_val;
    ex_mem_bus_in.rd         = id_ex_q.rd;
  end

  // ---------------- MEM ----------------
  if (1'b1) begin : dmem
    logic [31:0] DMem [0:DMEM_DEPTH-1];
    assign dmem_rword = DMem[ex_mem_q.alu_res[9:2]];
    // Store commits at the end of MEM; sb touches only the addressed byte lane
    always_ff @(posedge clock) begin
      if (ex_mem_q.mem_write) begin
        if (ex_mem_q.mem_byte)
          DMem[ex_mem_q.alu_res[9:2]][{ex_mem_q.alu_res[1:0], 3'b000} +: 8] <= ex_mem_q.store_data[7:0];
        else
          DMem[ex_mem_q.alu_res[9:2]] <= ex_mem_q.store_data;
      end
    end
  end

  // Load data selection (lb sign-extends its lane, lw ignores addr[1:0]) and MEM/WB next value
  always_comb begin
    load_byte = dmem_rword[{ex_mem_q.alu_res[1:0], 3'b000} +: 8];
    mem_wb_bus_in.reg_write = ex_mem_q.reg_write;
    mem_wb_bus_in.rd        = ex_mem_q.rd;
    mem_wb_bus_in.wdata     = ex_mem_q.alu_res;
    if (ex_mem_q.mem_read)
      mem_wb_bus_in.wdata = ex_mem_q.mem_byte ? {{24{load_byte[7]}}, load_byte} : dmem_rword;
  end

  // Pipeline registers; reset drops every in-flight instruction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      if_id_q  <= if_id_bus_in;
      id_ex_q  <= id_ex_bus_in;
      ex_mem_q <= ex_mem_bus_in;
      mem_wb_q <= mem_wb_bus_in;
    end
  end

  // ---------------- WB ----------------
  assign mem_wb_bus_out = mem_wb_q;

`ifdef DEBUG_TRACE_EN
  int unsigned trace_cycle_q;

  // Edge counter for the trace
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) trace_cycle_q <= 0;
    else        trace_cycle_q <= trace_cycle_q + 1;
  end

  // One trace line per rising edge
  always @(posedge clock) begin
    $display("cyc=%0d pc=%h ifid=%h idex=%p exmem=%p mwin=%p mwout=%p ctrl=%p",
             trace_cycle_q, pc_q, if_id_q.instr, id_ex_bus_in, ex_mem_bus_in,
             mem_wb_bus_in, mem_wb_bus_out, ctrl_signals);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_riscv_cpu.sv
// Directed self-checking bench for riscv_cpu: programs and data are preloaded
// through the DUT hierarchy while reset is held, then the core runs freely.
module tb_riscv_cpu;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  riscv_cpu dut (
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Hold reset and clear all memories and registers.
  task automatic prep();
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 256; i++) begin
      dut.imem.IMem[i] = 32'h0;
      dut.dmem.DMem[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) dut.regfile.Regs[i] = 32'h0;
  endtask

  task automatic go();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    prep();
    checks++; if (dut.if_stage.PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", dut.if_stage.PC, 32'h0); end
    checks++; if (dut.ctrl_signals !== '0) begin errors++; $display("FAIL rst_ctrl got %h exp 0", dut.ctrl_signals); end
    checks++; if (dut.mem_wb_bus_out !== '0) begin errors++; $display("FAIL rst_mwb got %h exp 0", dut.mem_wb_bus_out); end
    go();
    run(1);
    checks++; if (dut.if_stage.PC !== 32'h4) begin errors++; $display("FAIL rst_pc1 got %h exp %h", dut.if_stage.PC, 32'h4); end
    run(2);
    checks++; if (dut.if_stage.PC !== 32'hC) begin errors++; $display("FAIL rst_pc3 got %h exp %h", dut.if_stage.PC, 32'hC); end
  endtask

  task automatic test_load();
    prep();
    dut.dmem.DMem[0] = 32'h0000_0080;
    dut.imem.IMem[0] = enc_i(12'd0, 5'd0, 3'b000, 5'd1, 7'b0000011);  // lb x1,0(x0)
    dut.imem.IMem[1] = enc_i(12'd1, 5'd0, 3'b010, 5'd5, 7'b0000011);  // lw x5,1(x0)
    go();
    run(4);
    checks++; if (dut.regfile.Regs[1] !== 32'h0) begin errors++; $display("FAIL lb_early got %h exp %h", dut.regfile.Regs[1], 32'h0); end
    run(1);
    checks++; if (dut.regfile.Regs[1] !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_x1 got %h exp %h", dut.regfile.Regs[1], 32'hFFFF_FF80); end
    run(1);
    checks++; if (dut.regfile.Regs[5] !== 32'h0000_0080) begin errors++; $display("FAIL lw_x5 got %h exp %h", dut.regfile.Regs[5], 32'h0000_0080); end
  endtask

  task automatic test_store();
    prep();
    dut.regfile.Regs[2] = 32'hFFFF_00FF;
    dut.dmem.DMem[0] = 32'hAAAA_AAAA;
    dut.dmem.DMem[1] = 32'h1234_5600;
    dut.dmem.DMem[2] = 32'hBBBB_BBBB;
    dut.dmem.DMem[3] = 32'h1111_1111;
    dut.imem.IMem[0] = enc_s(12'd4, 5'd2, 5'd0, 3'b000);   // sb x2,4(x0)
    dut.imem.IMem[1] = enc_s(12'd8, 5'd2, 5'd0, 3'b010);   // sw x2,8(x0)
    dut.imem.IMem[2] = enc_s(12'd13, 5'd2, 5'd0, 3'b000);  // sb x2,13(x0)
    go();
    run(3);
    checks++; if (dut.dmem.DMem[1] !== 32'h1234_5600) begin errors++; $display("FAIL sb_early got %h exp %h", dut.dmem.DMem[1], 32'h1234_5600); end
    run(1);
    checks++; if (dut.dmem.DMem[1] !== 32'h1234_56FF) begin errors++; $display("FAIL sb_lane0 got %h exp %h", dut.dmem.DMem[1], 32'h1234_56FF); end
    checks++; if (dut.dmem.DMem[2] !== 32'hBBBB_BBBB) begin errors++; $display("FAIL sw_early got %h exp %h", dut.dmem.DMem[2], 32'hBBBB_BBBB); end
    run(2);
    checks++; if (dut.dmem.DMem[2] !== 32'hFFFF_00FF) begin errors++; $display("FAIL sw_word got %h exp %h", dut.dmem.DMem[2], 32'hFFFF_00FF); end
    checks++; if (dut.dmem.DMem[3] !== 32'h1111_FF11) begin errors++; $display("FAIL sb_lane1 got %h exp %h", dut.dmem.DMem[3], 32'h1111_FF11); end
    checks++; if (dut.dmem.DMem[0] !== 32'hAAAA_AAAA) begin errors++; $display("FAIL st_other got %h exp %h", dut.dmem.DMem[0], 32'hAAAA_AAAA); end
  endtask

  task automatic test_alu();
    prep();
    dut.regfile.Regs[10] = 32'h0000_0005;
    dut.regfile.Regs[11] = 32'hFFFF_FFF3;  // -13
    dut.imem.IMem[0] = enc_r(7'h20, 5'd11, 5'd10, 3'b000, 5'd12);  // sub
    dut.imem.IMem[1] = enc_r(7'h00, 5'd11, 5'd10, 3'b111, 5'd13);  // and
    dut.imem.IMem[2] = enc_r(7'h00, 5'd11, 5'd10, 3'b110, 5'd14);  // or
    dut.imem.IMem[3] = enc_r(7'h00, 5'd10, 5'd11, 3'b010, 5'd15);  // slt x15,x11,x10
    dut.imem.IMem[4] = enc_r(7'h00, 5'd11, 5'd10, 3'b010, 5'd16);  // slt x16,x10,x11
    dut.imem.IMem[5] = enc_i(12'hFF9, 5'd10, 3'b000, 5'd18, 7'b0010011);  // addi x18,x10,-7
    go();
    run(10);
    checks++; if (dut.regfile.Regs[12] !== 32'h0000_0012) begin errors++; $display("FAIL alu_sub got %h exp %h", dut.regfile.Regs[12], 32'h12); end
    checks++; if (dut.regfile.Regs[13] !== 32'h0000_0001) begin errors++; $display("FAIL alu_and got %h exp %h", dut.regfile.Regs[13], 32'h1); end
    checks++; if (dut.regfile.Regs[14] !== 32'hFFFF_FFF7) begin errors++; $display("FAIL alu_or got %h exp %h", dut.regfile.Regs[14], 32'hFFFF_FFF7); end
    checks++; if (dut.regfile.Regs[15] !== 32'h0000_0001) begin errors++; $display("FAIL alu_slt1 got %h exp %h", dut.regfile.Regs[15], 32'h1); end
    checks++; if (dut.regfile.Regs[16] !== 32'h0000_0000) begin errors++; $display("FAIL alu_slt0 got %h exp %h", dut.regfile.Regs[16], 32'h0); end
    checks++; if (dut.regfile.Regs[18] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL alu_addi got %h exp %h", dut.regfile.Regs[18], 32'hFFFF_FFFE); end
  endtask

  task automatic test_interlock();
    prep();
    dut.regfile.Regs[1] = 32'h1;
    dut.imem.IMem[0] = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd1);  // add x1,x1,x1
    dut.imem.IMem[1] = enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd1);  // add x1,x1,x1
    dut.imem.IMem[2] = enc_i(12'd3, 5'd0, 3'b000, 5'd6, 7'b0010011);  // addi x6,x0,3
    go();
    run(4);
    checks++; if (dut.if_stage.PC !== 32'h8) begin errors++; $display("FAIL stall_pc got %h exp %h", dut.if_stage.PC, 32'h8); end
    run(1);
    checks++; if (dut.regfile.Regs[1] !== 32'h2) begin errors++; $display("FAIL stall_x1a got %h exp %h", dut.regfile.Regs[1], 32'h2); end
    run(3);
    checks++; if (dut.regfile.Regs[1] !== 32'h4) begin errors++; $display("FAIL stall_x1b got %h exp %h", dut.regfile.Regs[1], 32'h4); end
    run(1);
    checks++; if (dut.regfile.Regs[6] !== 32'h3) begin errors++; $display("FAIL stall_x6 got %h exp %h", dut.regfile.Regs[6], 32'h3); end
  endtask

  task automatic test_branch();
    prep();
    dut.regfile.Regs[5] = 32'h1;
    dut.imem.IMem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd3, 7'b0010011);  // addi x3,x0,5
    dut.imem.IMem[1] = enc_b(13'd8, 5'd0, 5'd0);                      // beq x0,x0,+8
    dut.imem.IMem[2] = enc_i(12'd9, 5'd0, 3'b000, 5'd3, 7'b0010011);  // addi x3,x0,9
    dut.imem.IMem[3] = enc_i(12'd7, 5'd0, 3'b000, 5'd4, 7'b0010011);  // addi x4,x0,7
    dut.imem.IMem[4] = enc_b(13'd8, 5'd5, 5'd0);                      // beq x0,x5,+8 (not taken)
    dut.imem.IMem[5] = enc_i(12'd1, 5'd0, 3'b000, 5'd7, 7'b0010011);  // addi x7,x0,1
    dut.imem.IMem[6] = enc_i(12'd2, 5'd0, 3'b000, 5'd8, 7'b0010011);  // addi x8,x0,2
    go();
    run(8);
    checks++; if (dut.regfile.Regs[3] !== 32'h5) begin errors++; $display("FAIL br_skip got %h exp %h", dut.regfile.Regs[3], 32'h5); end
    run(4);
    checks++; if (dut.regfile.Regs[3] !== 32'h5) begin errors++; $display("FAIL br_x3 got %h exp %h", dut.regfile.Regs[3], 32'h5); end
    checks++; if (dut.regfile.Regs[4] !== 32'h7) begin errors++; $display("FAIL br_x4 got %h exp %h", dut.regfile.Regs[4], 32'h7); end
    checks++; if (dut.regfile.Regs[7] !== 32'h1) begin errors++; $display("FAIL bnt_x7 got %h exp %h", dut.regfile.Regs[7], 32'h1); end
    checks++; if (dut.regfile.Regs[8] !== 32'h2) begin errors++; $display("FAIL bnt_x8 got %h exp %h", dut.regfile.Regs[8], 32'h2); end
  endtask

  task automatic test_x0_nop();
    prep();
    dut.regfile.Regs[2]  = 32'hFFFF_00FF;
    dut.regfile.Regs[10] = 32'h5;
    dut.regfile.Regs[11] = 32'h3;
    dut.regfile.Regs[17] = 32'h55;
    dut.regfile.Regs[19] = 32'h77;
    dut.dmem.DMem[0] = 32'hCAFE_F00D;
    dut.imem.IMem[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);  // addi x0,x0,7
    dut.imem.IMem[1] = 32'hFFFF_FFFF;                                  // undefined
    dut.imem.IMem[2] = enc_r(7'h00, 5'd11, 5'd10, 3'b100, 5'd17);     // xor (unsupported)
    dut.imem.IMem[3] = enc_s(12'd0, 5'd2, 5'd0, 3'b001);              // sh (unsupported)
    dut.imem.IMem[4] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd19);       // add x19,x0,x0
    dut.imem.IMem[5] = enc_i(12'd1, 5'd0, 3'b000, 5'd9, 7'b0010011);  // addi x9,x0,1
    go();
    run(10);
    checks++; if (dut.regfile.Regs[0] !== 32'h0) begin errors++; $display("FAIL x0_reg got %h exp %h", dut.regfile.Regs[0], 32'h0); end
    checks++; if (dut.regfile.Regs[19] !== 32'h0) begin errors++; $display("FAIL x0_read got %h exp %h", dut.regfile.Regs[19], 32'h0); end
    checks++; if (dut.regfile.Regs[17] !== 32'h55) begin errors++; $display("FAIL nop_xor got %h exp %h", dut.regfile.Regs[17], 32'h55); end
    checks++; if (dut.dmem.DMem[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL nop_sh got %h exp %h", dut.dmem.DMem[0], 32'hCAFE_F00D); end
    checks++; if (dut.regfile.Regs[9] !== 32'h1) begin errors++; $display("FAIL nop_x9 got %h exp %h", dut.regfile.Regs[9], 32'h1); end
    checks++; if (dut.if_stage.PC !== 32'd40) begin errors++; $display("FAIL nop_pc got %h exp %h", dut.if_stage.PC, 32'd40); end
  endtask

  task automatic test_reset_midrun();
    prep();
    dut.regfile.Regs[22] = 32'h99;
    dut.regfile.Regs[25] = 32'hDEAD_BEEF;
    dut.dmem.DMem[5] = 32'h0BAD_F00D;
    dut.imem.IMem[0] = enc_i(12'd1, 5'd20, 3'b000, 5'd20, 7'b0010011);  // addi x20,x20,1
    dut.imem.IMem[3] = enc_s(12'd64, 5'd22, 5'd0, 3'b010);              // sw x22,64(x0)
    go();
    run(6);
    checks++; if (dut.regfile.Regs[20] !== 32'h1) begin errors++; $display("FAIL mr_x20a got %h exp %h", dut.regfile.Regs[20], 32'h1); end
    reset = 1'b0;
    #1;
    checks++; if (dut.if_stage.PC !== 32'h0) begin errors++; $display("FAIL mr_pc got %h exp %h", dut.if_stage.PC, 32'h0); end
    checks++; if (dut.ctrl_signals !== '0) begin errors++; $display("FAIL mr_ctrl got %h exp 0", dut.ctrl_signals); end
    checks++; if (dut.mem_wb_bus_out !== '0) begin errors++; $display("FAIL mr_mwb got %h exp 0", dut.mem_wb_bus_out); end
    run(1);
    checks++; if (dut.dmem.DMem[16] !== 32'h0) begin errors++; $display("FAIL mr_store_drop got %h exp %h", dut.dmem.DMem[16], 32'h0); end
    checks++; if (dut.regfile.Regs[25] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mr_reg_keep got %h exp %h", dut.regfile.Regs[25], 32'hDEAD_BEEF); end
    checks++; if (dut.dmem.DMem[5] !== 32'h0BAD_F00D) begin errors++; $display("FAIL mr_mem_keep got %h exp %h", dut.dmem.DMem[5], 32'h0BAD_F00D); end
    go();
    run(5);
    checks++; if (dut.regfile.Regs[20] !== 32'h2) begin errors++; $display("FAIL mr_x20b got %h exp %h", dut.regfile.Regs[20], 32'h2); end
    run(2);
    checks++; if (dut.dmem.DMem[16] !== 32'h99) begin errors++; $display("FAIL mr_store got %h exp %h", dut.dmem.DMem[16], 32'h99); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_alu();
    test_interlock();
    test_branch();
    test_x0_nop();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
